// File: rtl/fib_access_ctrl_if.sv
// Request, hash-unit and FIB-table signals of the FIB access controller.
// The slave modport is the controller; the master modport is its surroundings
// (PIT/data requesters, hash unit and table storage).
interface fib_access_ctrl_if #(
    parameter int PREFIX_W = 64,
    parameter int LEN_W    = 6,
    parameter int HASH_W   = 10
);
    logic                lk_valid;
    logic                lk_ready;
    logic [PREFIX_W-1:0] lk_prefix;
    logic [LEN_W-1:0]    lk_len;
    logic                lk_resp_valid;
    logic                lk_resp_hit;
    logic [LEN_W-1:0]    lk_resp_len;
    logic [PREFIX_W-1:0] lk_resp_prefix;

    logic                ins_valid;
    logic                ins_ready;
    logic [PREFIX_W-1:0] ins_prefix;
    logic [LEN_W-1:0]    ins_len;
    logic                ins_done;

    logic [PREFIX_W-1:0] hash_prefix;
    logic [LEN_W-1:0]    hash_len;
    logic [HASH_W-1:0]   hash_in;

    logic                tbl_rd_en;
    logic                tbl_wr_en;
    logic [LEN_W-1:0]    tbl_len;
    logic [HASH_W-1:0]   tbl_idx;
    logic [PREFIX_W-1:0] tbl_wr_prefix;
    logic                tbl_rd_valid;
    logic [PREFIX_W-1:0] tbl_rd_prefix;

    modport master (
        output lk_valid, lk_prefix, lk_len, ins_valid, ins_prefix, ins_len,
               hash_in, tbl_rd_valid, tbl_rd_prefix,
        input  lk_ready, lk_resp_valid, lk_resp_hit, lk_resp_len, lk_resp_prefix,
               ins_ready, ins_done, hash_prefix, hash_len,
               tbl_rd_en, tbl_wr_en, tbl_len, tbl_idx, tbl_wr_prefix
    );

    modport slave (
        input  lk_valid, lk_prefix, lk_len, ins_valid, ins_prefix, ins_len,
               hash_in, tbl_rd_valid, tbl_rd_prefix,
        output lk_ready, lk_resp_valid, lk_resp_hit, lk_resp_len, lk_resp_prefix,
               ins_ready, ins_done, hash_prefix, hash_len,
               tbl_rd_en, tbl_wr_en, tbl_len, tbl_idx, tbl_wr_prefix
    );
endinterface

// File: rtl/fib_access_ctrl.sv
// FIB access controller: round-robin arbitration between PIT lookups and
// data-side inserts, longest-prefix-match probe loop over the shared hash
// unit, and single-port FIB table sequencing. All hash/table/response outputs
// come straight from flops loaded with next-state decoded values.
module fib_access_ctrl #(
    parameter int PREFIX_W = 64,
    parameter int LEN_W    = 6,
    parameter int HASH_W   = 10,
    parameter int HASH_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    fib_access_ctrl_if.slave bus
);
    localparam int CNT_W = (HASH_LAT > 1) ? $clog2(HASH_LAT) : 1;

    typedef enum logic [2:0] {IDLE, HASH, RD, CHK, WR, DONE} state_t;

    state_t              state, state_nxt;
    logic                op, op_nxt;          // 0 = lookup, 1 = insert
    logic                turn, turn_nxt;      // 0 = lookup has priority
    logic                hit, hit_nxt;
    logic [PREFIX_W-1:0] w_prefix, prefix_nxt;
    logic [LEN_W-1:0]    w_len, len_nxt;
    logic [HASH_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                grant_lk, grant_ins, probe_hit;

    logic                lk_resp_valid_d, lk_resp_hit_d, ins_done_d;
    logic [LEN_W-1:0]    lk_resp_len_d, hash_len_d, tbl_len_d;
    logic [PREFIX_W-1:0] lk_resp_prefix_d, hash_prefix_d, tbl_wr_prefix_d;
    logic                tbl_rd_en_d, tbl_wr_en_d;
    logic [HASH_W-1:0]   tbl_idx_d;

    logic                lk_resp_valid_reg, lk_resp_hit_reg, ins_done_reg;
    logic [LEN_W-1:0]    lk_resp_len_reg, hash_len_reg, tbl_len_reg;
    logic [PREFIX_W-1:0] lk_resp_prefix_reg, hash_prefix_reg, tbl_wr_prefix_reg;
    logic                tbl_rd_en_reg, tbl_wr_en_reg;
    logic [HASH_W-1:0]   tbl_idx_reg;

    // Keep the top l bits of p (MSB-first), zero the rest.
    function automatic logic [PREFIX_W-1:0] mask_prefix(input logic [PREFIX_W-1:0] p,
                                                        input logic [LEN_W-1:0] l);
        if (l == '0) return '0;
        return p & ({PREFIX_W{1'b1}} << (PREFIX_W - int'(l)));
    endfunction

    assign grant_lk  = !rst && (state == IDLE) && bus.lk_valid  && (!bus.ins_valid || !turn);
    assign grant_ins = !rst && (state == IDLE) && bus.ins_valid && (!bus.lk_valid  ||  turn);
    assign probe_hit = bus.tbl_rd_valid && (bus.tbl_rd_prefix == w_prefix);

    assign bus.lk_ready       = grant_lk;
    assign bus.ins_ready      = grant_ins;
    assign bus.lk_resp_valid  = lk_resp_valid_reg;
    assign bus.lk_resp_hit    = lk_resp_hit_reg;
    assign bus.lk_resp_len    = lk_resp_len_reg;
    assign bus.lk_resp_prefix = lk_resp_prefix_reg;
    assign bus.ins_done       = ins_done_reg;
    assign bus.hash_prefix    = hash_prefix_reg;
    assign bus.hash_len       = hash_len_reg;
    assign bus.tbl_rd_en      = tbl_rd_en_reg;
    assign bus.tbl_wr_en      = tbl_wr_en_reg;
    assign bus.tbl_len        = tbl_len_reg;
    assign bus.tbl_idx        = tbl_idx_reg;
    assign bus.tbl_wr_prefix  = tbl_wr_prefix_reg;

    // State, working registers and registered outputs; reset abandons any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            op                 <= 1'b0;
            turn               <= 1'b0;
            hit                <= 1'b0;
            w_prefix           <= '0;
            w_len              <= '0;
            idx                <= '0;
            cnt                <= '0;
            lk_resp_valid_reg  <= 1'b0;
            lk_resp_hit_reg    <= 1'b0;
            lk_resp_len_reg    <= '0;
            lk_resp_prefix_reg <= '0;
            ins_done_reg       <= 1'b0;
            hash_prefix_reg    <= '0;
            hash_len_reg       <= '0;
            tbl_rd_en_reg      <= 1'b0;
            tbl_wr_en_reg      <= 1'b0;
            tbl_len_reg        <= '0;
            tbl_idx_reg        <= '0;
            tbl_wr_prefix_reg  <= '0;
        end else begin
            state              <= state_nxt;
            op                 <= op_nxt;
            turn               <= turn_nxt;
            hit                <= hit_nxt;
            w_prefix           <= prefix_nxt;
            w_len              <= len_nxt;
            idx                <= idx_nxt;
            cnt                <= cnt_nxt;
            lk_resp_valid_reg  <= lk_resp_valid_d;
            lk_resp_hit_reg    <= lk_resp_hit_d;
            lk_resp_len_reg    <= lk_resp_len_d;
            lk_resp_prefix_reg <= lk_resp_prefix_d;
            ins_done_reg       <= ins_done_d;
            hash_prefix_reg    <= hash_prefix_d;
            hash_len_reg       <= hash_len_d;
            tbl_rd_en_reg      <= tbl_rd_en_d;
            tbl_wr_en_reg      <= tbl_wr_en_d;
            tbl_len_reg        <= tbl_len_d;
            tbl_idx_reg        <= tbl_idx_d;
            tbl_wr_prefix_reg  <= tbl_wr_prefix_d;
        end
    end

    // Next state plus working-register updates: grant, hash wait, probe loop.
    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        turn_nxt   = turn;
        hit_nxt    = hit;
        prefix_nxt = w_prefix;
        len_nxt    = w_len;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (grant_lk || grant_ins) begin
                    op_nxt     = grant_ins;
                    turn_nxt   = ~turn;
                    hit_nxt    = 1'b0;
                    cnt_nxt    = '0;
                    len_nxt    = grant_ins ? bus.ins_len : bus.lk_len;
                    prefix_nxt = mask_prefix(grant_ins ? bus.ins_prefix : bus.lk_prefix, len_nxt);
                    state_nxt  = (len_nxt == '0) ? DONE : HASH;
                end
            end
            HASH: begin
                if (cnt == CNT_W'(HASH_LAT - 1)) begin
                    idx_nxt   = bus.hash_in;
                    state_nxt = op ? WR : RD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RD:   state_nxt = CHK;
            CHK: begin
                if (probe_hit) begin
                    hit_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (w_len > LEN_W'(1)) begin
                    len_nxt    = w_len - LEN_W'(1);
                    prefix_nxt = mask_prefix(w_prefix, len_nxt);
                    cnt_nxt    = '0;
                    state_nxt  = HASH;
                end else begin
                    state_nxt = DONE;
                end
            end
            WR:   state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the coming state, loaded into the output flops.
    always_comb begin
        hash_prefix_d    = (state_nxt == HASH) ? prefix_nxt : '0;
        hash_len_d       = (state_nxt == HASH) ? len_nxt : '0;
        tbl_rd_en_d      = (state_nxt == RD);
        tbl_wr_en_d      = (state_nxt == WR);
        tbl_len_d        = (tbl_rd_en_d || tbl_wr_en_d) ? len_nxt : '0;
        tbl_idx_d        = (tbl_rd_en_d || tbl_wr_en_d) ? idx_nxt : '0;
        tbl_wr_prefix_d  = tbl_wr_en_d ? prefix_nxt : '0;
        lk_resp_valid_d  = (state_nxt == DONE) && !op_nxt;
        lk_resp_hit_d    = lk_resp_valid_d && hit_nxt;
        lk_resp_len_d    = lk_resp_hit_d ? len_nxt : '0;
        lk_resp_prefix_d = lk_resp_hit_d ? prefix_nxt : '0;
        ins_done_d       = (state_nxt == DONE) && op_nxt;
    end
endmodule

// File: tb/tb_fib_access_ctrl.sv
// Directed bench for fib_access_ctrl with a behavioural hash unit and table.
module tb_fib_access_ctrl;
    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 6;
    localparam int HASH_W   = 10;
    localparam int HASH_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fib_access_ctrl_if #(.PREFIX_W(PREFIX_W), .LEN_W(LEN_W), .HASH_W(HASH_W)) bus ();

    fib_access_ctrl #(.PREFIX_W(PREFIX_W), .LEN_W(LEN_W), .HASH_W(HASH_W), .HASH_LAT(HASH_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int both_ready  = 0;
    int both_strobe = 0;

    bit [63:0] tmem [64][1024];
    bit        tvld [64][1024];

    // Hash unit: fixed XOR fold of its masked inputs.
    assign bus.hash_in = bus.hash_prefix[63:54] ^ bus.hash_prefix[9:0] ^ {4'b0, bus.hash_len};

    // Table: writes land at the edge, read data appears one cycle after tbl_rd_en.
    always @(posedge clk) begin
        if (bus.tbl_wr_en) begin
            tmem[bus.tbl_len][bus.tbl_idx] <= bus.tbl_wr_prefix;
            tvld[bus.tbl_len][bus.tbl_idx] <= 1'b1;
        end
        if (bus.tbl_rd_en) begin
            bus.tbl_rd_valid  <= tvld[bus.tbl_len][bus.tbl_idx];
            bus.tbl_rd_prefix <= tmem[bus.tbl_len][bus.tbl_idx];
        end else begin
            bus.tbl_rd_valid  <= 1'b0;
            bus.tbl_rd_prefix <= '0;
        end
    end

    // Protocol watch: never both readies, never both table strobes.
    always @(negedge clk) begin
        if (bus.lk_ready && bus.ins_ready) both_ready <= both_ready + 1;
        if (bus.tbl_rd_en && bus.tbl_wr_en) both_strobe <= both_strobe + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         lat, rds, wrs, wr_cyc;
    logic [63:0] wr_pref;
    logic [5:0]  wr_len;
    logic        resp_hit;
    logic [5:0]  resp_len;
    logic [63:0] resp_pref;

    // Issue one request alone and follow it until its completion pulse.
    task automatic run_txn(input string tag, input bit is_ins, input logic [63:0] pfx,
                           input logic [5:0] len, input int budget);
        lat = -1; rds = 0; wrs = 0; wr_cyc = -1;
        wr_pref = '0; wr_len = '0; resp_hit = 1'b0; resp_len = '0; resp_pref = '0;
        @(negedge clk);
        if (is_ins) begin
            bus.ins_valid = 1'b1; bus.ins_prefix = pfx; bus.ins_len = len;
        end else begin
            bus.lk_valid = 1'b1; bus.lk_prefix = pfx; bus.lk_len = len;
        end
        #1;
        check({tag, "_ready"}, is_ins ? bus.ins_ready : bus.lk_ready, 1);
        @(posedge clk);
        #1;
        bus.ins_valid = 1'b0;
        bus.lk_valid  = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.tbl_rd_en) rds++;
            if (bus.tbl_wr_en) begin
                wrs++; wr_cyc = c; wr_pref = bus.tbl_wr_prefix; wr_len = bus.tbl_len;
            end
            if (is_ins ? bus.ins_done : bus.lk_resp_valid) begin
                lat = c;
                resp_hit = bus.lk_resp_hit; resp_len = bus.lk_resp_len; resp_pref = bus.lk_resp_prefix;
                break;
            end
        end
    endtask

    int   grants [6];
    int   g;
    int   late;

    initial begin
        // Reset with both requesters valid.
        bus.lk_valid = 1'b1;  bus.lk_prefix = 64'h1234_5678_9ABC_DEF0;  bus.lk_len = 6'd8;
        bus.ins_valid = 1'b1; bus.ins_prefix = 64'hFFFF_0000_FFFF_0000; bus.ins_len = 6'd4;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {bus.lk_ready, bus.ins_ready}, 0);
        check("rst_outputs", |{bus.lk_resp_valid, bus.lk_resp_hit, bus.lk_resp_len, bus.lk_resp_prefix,
                               bus.ins_done, bus.hash_prefix, bus.hash_len, bus.tbl_rd_en, bus.tbl_wr_en,
                               bus.tbl_len, bus.tbl_idx, bus.tbl_wr_prefix}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {bus.lk_ready, bus.ins_ready}, 2'b10);
        bus.lk_valid = 1'b0;
        bus.ins_valid = 1'b0;

        // Insert 0xAB/8: write at cycle 2, done at cycle 3.
        run_txn("ins_ab", 1'b1, 64'hAB12_3400_0000_0000, 6'd8, 20);
        check("ins_lat", lat, 3);
        check("ins_wr_cyc", wr_cyc, 2);
        check("ins_wrs", wrs, 1);
        check("ins_wr_prefix", wr_pref, 64'hAB00_0000_0000_0000);
        check("ins_wr_len", wr_len, 8);

        // Lookup 0xABCD/16: nine probes (16..8), hit at 8, response at cycle 28.
        run_txn("lk_hit", 1'b0, 64'hABCD_1234_5678_9ABC, 6'd16, 60);
        check("lk_hit_lat", lat, 28);
        check("lk_hit_probes", rds, 9);
        check("lk_hit_flag", resp_hit, 1);
        check("lk_hit_len", resp_len, 8);
        check("lk_hit_prefix", resp_pref, 64'hAB00_0000_0000_0000);

        // Full miss from length 3: response at cycle 10.
        run_txn("lk_miss", 1'b0, 64'hE000_0000_0000_0000, 6'd3, 40);
        check("lk_miss_lat", lat, 10);
        check("lk_miss_probes", rds, 3);
        check("lk_miss_flag", resp_hit, 0);
        check("lk_miss_len", resp_len, 0);
        check("lk_miss_prefix", resp_pref, 0);

        // Length-0 lookup and insert: done at cycle 1, no table access.
        run_txn("lk_len0", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 10);
        check("lk_len0_lat", lat, 1);
        check("lk_len0_strobes", rds + wrs, 0);
        check("lk_len0_hit", resp_hit, 0);
        check("lk_len0_prefix", resp_pref, 0);
        run_txn("ins_len0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 10);
        check("ins_len0_lat", lat, 1);
        check("ins_len0_strobes", rds + wrs, 0);

        // Reset during CHK of a length-2 lookup (grant=0, HASH=1, RD=2, CHK=3).
        @(negedge clk);
        bus.lk_valid = 1'b1; bus.lk_prefix = 64'hC000_0000_0000_0000; bus.lk_len = 6'd2;
        @(posedge clk);
        #1;
        bus.lk_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        late = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.lk_resp_valid || bus.ins_done || bus.tbl_rd_en || bus.tbl_wr_en) late++;
        end
        check("mid_rst_quiet", late, 0);
        run_txn("lk_after_rst", 1'b0, 64'hAB99_0000_0000_0000, 6'd8, 20);
        check("lk_after_rst_lat", lat, 4);
        check("lk_after_rst_hit", resp_hit, 1);
        check("lk_after_rst_len", resp_len, 8);

        // Round robin with both held valid; turn is at insert after the last lookup grant.
        @(negedge clk);
        bus.lk_prefix = 64'h8000_0000_0000_0000;  bus.lk_len = 6'd0;
        bus.ins_prefix = 64'hF000_0000_0000_0000; bus.ins_len = 6'd4;
        bus.lk_valid = 1'b1; bus.ins_valid = 1'b1;
        g = 0;
        for (int c = 0; c < 200 && g < 6; c++) begin
            #1;
            if (bus.ins_ready) begin grants[g] = 1; g++; end
            else if (bus.lk_ready) begin grants[g] = 0; g++; end
            @(negedge clk);
        end
        bus.lk_valid = 1'b0; bus.ins_valid = 1'b0;
        check("rr_grant_count", g, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 0) ? 1 : 0);

        repeat (8) @(negedge clk);
        check("never_both_ready", both_ready, 0);
        check("never_both_strobes", both_strobe, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
